data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Word-organised data memory controller on the RISCV core's data-memory port, downstream of the core's memory-access stage. Accepts single read or write requests, applies a configurable wait-state latency, and returns read data or write completion with a one-cycle ready pulse, plus an error flag for illegal accesses. It replaces the tied-high ready / zero-latency memory used in early bring-up so the core's stall logic can be exercised.

## Interface

- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two ≥ 4; IDX_W = $clog2(DEPTH_WORDS).
- WAIT_STATES, 2: extra cycles between acceptance and response; legal range 0–15.

Ports:

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_rd_en  in  1  read request (core `o_data_rd_en_ma`).
- i_wr_en  in  1  write request (core `o_data_wr_en_ma`).
- i_addr  in  32  byte address (core `o_data_addr`).
- i_wdata  in  32  write data (core `o_data_wr`).
- i_wstrb  in  4  byte-lane write enables; bit k covers i_wdata[8k+7:8k].
- o_rdata  out  32  read data (core `i_data_rd`); valid only while o_ready=1.
- o_ready  out  1  one-cycle completion pulse (core `i_data_ready`).
- o_err  out  1  access error; valid only while o_ready=1.

## Operation

- Storage: DEPTH_WORDS × 32-bit array, not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if i_rd_en or i_wr_en is high at a clock edge, latch addr/wdata/wstrb/op, load the wait counter with WAIT_STATES, and go to BUSY. If WAIT_STATES=0, go straight to RESP instead.
- BUSY: decrement the counter each cycle. On the edge where the counter is 1, go to RESP. Inputs are ignored; the latched copy is used.
- RESP: o_ready=1 for exactly one cycle, then return to IDLE. Inputs are ignored during RESP, so a new request is sampled no earlier than the first IDLE cycle.
- Commit: the array write and the read capture into o_rdata happen on the edge that enters RESP.
- Error conditions; any one of them sets o_err=1 in RESP, suppresses the write, and forces o_rdata=0:
  - i_addr[1:0] ≠ 0 (misaligned);
  - i_addr[31:2] ≥ DEPTH_WORDS (out of range; the full-width comparison is made, with no aliasing);
  - i_rd_en and i_wr_en both high.
- Write: for each k with i_wstrb[k]=1, word[idx] byte k takes the new data; other bytes are retained. A write with wstrb=0 completes with o_err=0 and leaves memory unchanged. o_rdata=0 on a write response.
- Read: o_rdata = word[idx], where idx = latched addr[IDX_W+1:2].
- Read after write: a read accepted after a write's RESP returns the updated word.

## Timing

- Reset values: state=IDLE, counter=0, o_ready=0, o_err=0, o_rdata=0.
- Request accepted at edge N (in IDLE). o_ready is high during cycle N+1+WAIT_STATES.
- Throughput: one access per WAIT_STATES+2 cycles when requests are held continuously.
- The core must hold its enables and operands until it sees o_ready. It must deassert them, or present the next request, by the edge that ends the RESP cycle. A held request is re-accepted in the following IDLE cycle.
- o_ready, o_err and o_rdata are all registered; there are no combinational input-to-output paths.
- Reset asserted in BUSY: the access is aborted, no array write occurs, no o_ready is produced, and the controller is in IDLE on the edge after rst deasserts.
- Reset asserted in RESP: o_ready drops on the next edge. The write has already committed at RESP entry and is kept.
- Outside RESP, o_rdata is held at 0.

## Test plan

- Reset, then WAIT_STATES=2: write 0xDEADBEEF to 0x10 with wstrb=0xF, accepted at edge N. Required: o_ready in cycle N+3 with o_err=0. Then read 0x10: o_rdata=0xDEADBEEF with o_ready.
- Partial write: write 0x000000AA to 0x10 with wstrb=0x1, then read 0x10. Required: 0xDEADBEAA. A further write with wstrb=0x0 leaves the word unchanged.
- Errors, each returning o_ready with o_err=1, o_rdata=0 and memory unchanged:
  - read 0x12 (misaligned);
  - write to 0x1000 with DEPTH_WORDS=1024 (out of range);
  - request with rd_en and wr_en both high.
- WAIT_STATES=0, back-to-back reads held continuously at 0x0 and 0x4. Required: o_ready every 2nd cycle with the correct data each time.
- Reset during BUSY of a write of 0x12345678 to 0x20. Required: no o_ready is produced, and a subsequent read of 0x20 returns the prior contents.
- Operand change during BUSY: change i_addr to 0x40 mid-access. Required: the response reflects the originally latched address 0x20.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory controller with configurable wait states,
// one-cycle ready pulse and error flag for misaligned/out-of-range/conflicting accesses.
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rd_en,
   input  logic        i_wr_en,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_err
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        rd_q, rd_d, wr_q, wr_d;
   logic        ready_q, ready_d, err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic             commit;
   logic [31:0]      cur_addr, cur_wdata;
   logic [3:0]       cur_wstrb;
   logic             cur_rd, cur_wr, cur_err;
   logic [IDX_W-1:0] cur_idx;

   // With zero wait states the commit happens on the accepting edge, so the
   // operands come straight from the inputs rather than the latched copy.
   always_comb begin
      if (state_q == IDLE) begin
         cur_addr  = i_addr;
         cur_wdata = i_wdata;
         cur_wstrb = i_wstrb;
         cur_rd    = i_rd_en;
         cur_wr    = i_wr_en;
      end else begin
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_wstrb = wstrb_q;
         cur_rd    = rd_q;
         cur_wr    = wr_q;
      end
      cur_err = (|cur_addr[1:0])
              || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS))
              || (cur_rd && cur_wr);
      cur_idx = cur_addr[IDX_W+1:2];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      commit  = 1'b0;
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (i_rd_en || i_wr_en) begin
               addr_d  = i_addr;
               wdata_d = i_wdata;
               wstrb_d = i_wstrb;
               rd_d    = i_rd_en;
               wr_d    = i_wr_en;
               if (WS == 4'd0) begin
                  state_d = RESP;
                  cnt_d   = 4'd0;
                  commit  = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = WS;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               commit  = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (commit) begin
         ready_d = 1'b1;
         err_d   = cur_err;
         rdata_d = (cur_rd && !cur_err) ? mem[cur_idx] : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is not reset; a reset on the commit edge still suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && commit && cur_wr && !cur_err) begin
         for (int k = 0; k < 4; k++) begin
            if (cur_wstrb[k]) mem[cur_idx][8*k +: 8] <= cur_wdata[8*k +: 8];
         end
      end
   end

   assign o_ready = ready_q;
   assign o_err   = err_q;
   assign o_rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: two instances (2 and 0 wait states),
// directed vector table, hand-written corner sequences and randomized traffic vs a word-array model.
module tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd2 = 0, wr2 = 0, rd0 = 0, wr0 = 0;
   logic [31:0] addr2 = 0, wdata2 = 0, addr0 = 0, wdata0 = 0;
   logic [3:0]  wstrb2 = 0, wstrb0 = 0;
   logic [31:0] rdata2, rdata0;
   logic        rdy2, rdy0, err2, err0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut2 (
      .clk(clk), .rst(rst), .i_rd_en(rd2), .i_wr_en(wr2), .i_addr(addr2),
      .i_wdata(wdata2), .i_wstrb(wstrb2), .o_rdata(rdata2), .o_ready(rdy2), .o_err(err2));

   data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst), .i_rd_en(rd0), .i_wr_en(wr0), .i_addr(addr0),
      .i_wdata(wdata0), .i_wstrb(wstrb0), .o_rdata(rdata0), .o_ready(rdy0), .o_err(err0));

   bit          cur_sel = 1'b0;
   logic        cur_ready, cur_err;
   logic [31:0] cur_rdata;
   assign cur_ready = cur_sel ? rdy0 : rdy2;
   assign cur_err   = cur_sel ? err0 : err2;
   assign cur_rdata = cur_sel ? rdata0 : rdata2;

   int errors = 0;
   int checks = 0;
   logic [31:0] mdl [2][1024];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[$];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
      cur_sel = sel;
      if (sel) begin
         rd0 = rd; wr0 = wr; addr0 = a; wdata0 = wd; wstrb0 = s;
      end else begin
         rd2 = rd; wr2 = wr; addr2 = a; wdata2 = wd; wstrb2 = s;
      end
   endtask

   task automatic wait_ready(output int lat, output logic [31:0] r, output logic e);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!cur_ready && lat < 40);
      r = cur_rdata;
      e = cur_err;
      if (!cur_ready) lat = -1;
   endtask

   task automatic txn(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      output int lat, output logic [31:0] r, output logic e);
      @(negedge clk);
      drive(sel, rd, wr, a, wd, s);
      wait_ready(lat, r, e);
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   // Reference: byte-addressed word memory, errors decided from the address arithmetic.
   task automatic model_apply(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] s,
                              output logic e, output logic [31:0] r);
      int idx;
      e = ((a % 4) != 0) || ((a / 4) >= 1024) || (rd && wr);
      r = 32'h0;
      if (!e) begin
         idx = int'(a / 4);
         if (wr) begin
            for (int k = 0; k < 4; k++)
               if (s[k]) mdl[sel][idx][8*k +: 8] = wd[8*k +: 8];
         end else begin
            r = mdl[sel][idx];
         end
      end
   endtask

   task automatic chk_txn(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] s, input string name);
      logic e_exp, e_act;
      logic [31:0] r_exp, r_act;
      int lat;
      model_apply(sel, rd, wr, a, wd, s, e_exp, r_exp);
      txn(sel, rd, wr, a, wd, s, lat, r_act, e_act);
      check32({name, " latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
      check32({name, " err"}, {31'h0, e_act}, {31'h0, e_exp});
      check32({name, " rdata"}, r_act, r_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic e;
      logic [31:0] r;
      bit saw;
      int expidx;

      vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 1'b1, 32'h10,       32'h000000AA, 4'h1, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEAA});
      vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEAA});
      vecs.push_back('{1'b1, 1'b0, 32'h12,       32'h0,        4'h0, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 32'h12,       32'h55555555, 4'hF, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 32'h1000,     32'h11111111, 4'hF, 1'b1, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 32'h10,       32'h22222222, 4'hF, 1'b1, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEAA});
      vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h10000000});
      vecs.push_back('{1'b0, 1'b1, 32'hFFC,      32'h0BADF00D, 4'hF, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 32'hFFC,      32'h0,        4'h0, 1'b0, 32'h0BADF00D});
      vecs.push_back('{1'b1, 1'b0, 32'h1000,     32'h0,        4'h0, 1'b1, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 32'h80000FFC, 32'h0,        4'h0, 1'b1, 32'h0});

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check32("reset dut2 ready", {31'h0, rdy2}, 32'h0);
      check32("reset dut2 err", {31'h0, err2}, 32'h0);
      check32("reset dut2 rdata", rdata2, 32'h0);
      check32("reset dut0 ready", {31'h0, rdy0}, 32'h0);
      check32("reset dut0 rdata", rdata0, 32'h0);

      for (int i = 0; i < 32; i++) begin
         chk_txn(1'b0, 1'b0, 1'b1, 32'(i * 4), 32'h10000000 + 32'(i) * 32'h00010101, 4'hF, "init2");
         chk_txn(1'b1, 1'b0, 1'b1, 32'(i * 4), 32'h20000000 + 32'(i) * 32'h00030001, 4'hF, "init0");
      end

      foreach (vecs[i]) begin
         logic me;
         logic [31:0] mr;
         model_apply(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, me, mr);
         txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, r, e);
         check32($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
         check32($sformatf("vec%0d err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
         check32($sformatf("vec%0d rdata", i), r, vecs[i].exp_rdata);
      end

      // Reset while a write is in BUSY: no response, no memory update.
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rdy2) saw = 1'b1;
      end
      check32("abort no ready", {31'h0, saw}, 32'h0);
      chk_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "abort readback");

      // Address change while BUSY: the latched address wins.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      @(negedge clk);
      addr2 = 32'h40;
      wait_ready(lat, r, e);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      check32("latched addr ready", {31'h0, lat > 0}, 32'h1);
      check32("latched addr rdata", r, mdl[0][8]);

      // Zero wait states, reads held continuously alternating 0x0 / 0x4.
      @(negedge clk);
      expidx = 0;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            check32($sformatf("b2b ready%0d", i), {31'h0, rdy0}, 32'h1);
            check32($sformatf("b2b rdata%0d", i), rdata0, mdl[1][expidx]);
            expidx ^= 1;
            addr0 = 32'(expidx * 4);
         end else begin
            check32($sformatf("b2b gap%0d", i), {31'h0, rdy0}, 32'h0);
            check32($sformatf("b2b gap rdata%0d", i), rdata0, 32'h0);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      for (int i = 0; i < 80; i++) begin
         bit sel;
         int kind;
         logic rd, wr;
         logic [31:0] a;
         sel  = (i % 2) == 1;
         kind = $urandom_range(0, 9);
         a    = 32'($urandom_range(0, 31)) * 4;
         rd   = 1'b0;
         wr   = 1'b0;
         if (kind < 4) wr = 1'b1;
         else if (kind < 8) rd = 1'b1;
         else if (kind == 8) begin
            a  = a + 32'($urandom_range(1, 3));
            rd = $urandom_range(0, 1) == 1;
            wr = !rd;
         end else begin
            a  = ($urandom | 32'h1000) & 32'hFFFFFFFC;
            rd = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 1) == 1 || !rd;
         end
         chk_txn(sel, rd, wr, a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
